// File: rtl/fdas_calbus_pkg.sv
// Shared types and widths for the EMIF calibration-bus arbiter.
package fdas_calbus_pkg;

    localparam int CALBUS_ADDR_W = 20;
    localparam int CALBUS_DATA_W = 32;

    typedef enum logic {
        CAL_OWN = 1'b0,
        HOST    = 1'b1
    } calbus_state_e;

    typedef struct packed {
        logic                     read;
        logic                     write;
        logic [CALBUS_ADDR_W-1:0] address;
        logic [CALBUS_DATA_W-1:0] wdata;
    } calbus_req_t;

endpackage

// File: rtl/fdas_calbus_rd_tracker.sv
// Tracks the single outstanding host read across the fixed calbus read latency,
// flagging it as corrupted if calibration traffic appears while it is in flight.
module fdas_calbus_rd_tracker #(
    parameter int RD_LATENCY = 2
) (
    input  logic calbus_clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic cal_act_i,
    output logic rd_valid_o,
    output logic rd_err_o,
    output logic rd_busy_o
);

    logic [RD_LATENCY-1:0] valid_q, valid_d;
    logic [RD_LATENCY-1:0] err_q, err_d;

    always_comb begin
        valid_d    = '0;
        err_d      = '0;
        valid_d[0] = push_i;
        for (int k = 1; k < RD_LATENCY; k++) begin
            valid_d[k] = valid_q[k-1];
            err_d[k]   = err_q[k-1] | (valid_q[k-1] & cal_act_i);
        end
        // The return cycle itself is not busy, so a follow-up read can issue on it.
        rd_busy_o = 1'b0;
        for (int k = 0; k < RD_LATENCY - 1; k++) begin
            rd_busy_o = rd_busy_o | valid_q[k];
        end
    end

    always_ff @(posedge calbus_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rd_valid_o = valid_q[RD_LATENCY-1];
    assign rd_err_o   = valid_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];

endmodule

// File: rtl/fdas_calbus_arbiter.sv
// Calbus arbiter: calibration IP always wins, host granted after a quiet window.
// Optional statistics counters enabled by defining FDAS_CALBUS_ARB_STATS_EN.
//
// state   | meaning
// CAL_OWN | calibration owns the bus; counting consecutive idle cycles
// HOST    | host may issue; any cal strobe preempts back to CAL_OWN
module fdas_calbus_arbiter
    import fdas_calbus_pkg::*;
#(
    parameter int ADDR_W       = CALBUS_ADDR_W,
    parameter int DATA_W       = CALBUS_DATA_W,
    parameter int RD_LATENCY   = 2,
    parameter int QUIET_CYCLES = 64
) (
    input  logic              calbus_clk,
    input  logic              rst_n,
    input  logic              cal_read,
    input  logic              cal_write,
    input  logic [ADDR_W-1:0] cal_address,
    input  logic [DATA_W-1:0] cal_wdata,
    output logic [DATA_W-1:0] cal_rdata,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_readdatavalid,
    output logic              host_resp_err,
    output logic              host_grant,
    output logic              conflict_err,
    output logic              emif_read,
    output logic              emif_write,
    output logic [ADDR_W-1:0] emif_address,
    output logic [DATA_W-1:0] emif_wdata,
    input  logic [DATA_W-1:0] emif_rdata
`ifdef FDAS_CALBUS_ARB_STATS_EN
    ,
    output logic [15:0]       host_acc_cnt,
    output logic [15:0]       preempt_cnt
`endif
);

    localparam logic [7:0] QUIET_M1 = 8'(QUIET_CYCLES - 1);

    calbus_state_e state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          conflict_q, conflict_d;
    logic          cal_act, in_host, rd_busy, host_acc, host_rd_acc;
    calbus_req_t   emif_req;

    assign cal_act = cal_read | cal_write;
    assign in_host = (state_q == HOST);

    always_comb begin
        host_waitrequest = ~in_host | cal_act | rd_busy;
        host_acc         = (host_read | host_write) & ~host_waitrequest;
        host_rd_acc      = host_acc & host_read;
        emif_req         = '0;
        if (cal_act) begin
            emif_req.read    = cal_read;
            emif_req.write   = cal_write;
            emif_req.address = cal_address;
            emif_req.wdata   = cal_wdata;
        end else if (host_acc) begin
            // A simultaneous read and write issues only the read.
            emif_req.read    = host_read;
            emif_req.write   = host_write & ~host_read;
            emif_req.address = host_address;
            emif_req.wdata   = host_wdata;
        end
    end

    assign emif_read    = emif_req.read;
    assign emif_write   = emif_req.write;
    assign emif_address = emif_req.address;
    assign emif_wdata   = emif_req.wdata;
    assign cal_rdata    = emif_rdata;
    assign host_grant   = in_host;
    assign conflict_err = conflict_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = conflict_q | (cal_act & rd_busy);
        case (state_q)
            CAL_OWN: begin
                if (cal_act) begin
                    cnt_d = '0;
                end else if (cnt_q == QUIET_M1) begin
                    state_d = HOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOST: begin
                cnt_d = '0;
                if (cal_act) state_d = CAL_OWN;
            end
            default: begin
                state_d = CAL_OWN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge calbus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CAL_OWN;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    fdas_calbus_rd_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .calbus_clk (calbus_clk),
        .rst_n      (rst_n),
        .push_i     (host_rd_acc),
        .cal_act_i  (cal_act),
        .rd_valid_o (host_readdatavalid),
        .rd_err_o   (host_resp_err),
        .rd_busy_o  (rd_busy)
    );

    assign host_readdata = host_readdatavalid ? emif_rdata : '0;

`ifdef FDAS_CALBUS_ARB_STATS_EN
    logic [15:0] acc_cnt_q, preempt_cnt_q;

    always_ff @(posedge calbus_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q     <= '0;
            preempt_cnt_q <= '0;
        end else begin
            if (host_acc && acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
            if (in_host && cal_act && preempt_cnt_q != 16'hFFFF) preempt_cnt_q <= preempt_cnt_q + 16'd1;
        end
    end

    assign host_acc_cnt = acc_cnt_q;
    assign preempt_cnt  = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_fdas_calbus_arbiter.sv
// Scoreboard bench for fdas_calbus_arbiter: expected host reads queued at acceptance.
`timescale 1ns/1ps
module tb_fdas_calbus_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int QUIET  = 64;

    logic              calbus_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cal_read = 1'b0, cal_write = 1'b0;
    logic [ADDR_W-1:0] cal_address = '0;
    logic [DATA_W-1:0] cal_wdata = '0;
    logic [DATA_W-1:0] cal_rdata;
    logic              host_read = 1'b0, host_write = 1'b0;
    logic [ADDR_W-1:0] host_address = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_waitrequest, host_readdatavalid, host_resp_err;
    logic [DATA_W-1:0] host_readdata;
    logic              host_grant, conflict_err;
    logic              emif_read, emif_write;
    logic [ADDR_W-1:0] emif_address;
    logic [DATA_W-1:0] emif_wdata;
    logic [DATA_W-1:0] emif_rdata = '0;
`ifdef FDAS_CALBUS_ARB_STATS_EN
    logic [15:0]       host_acc_cnt, preempt_cnt;
`endif

    fdas_calbus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .QUIET_CYCLES(QUIET)
    ) dut (
        .calbus_clk(calbus_clk), .rst_n(rst_n),
        .cal_read(cal_read), .cal_write(cal_write), .cal_address(cal_address),
        .cal_wdata(cal_wdata), .cal_rdata(cal_rdata),
        .host_read(host_read), .host_write(host_write), .host_address(host_address),
        .host_wdata(host_wdata), .host_waitrequest(host_waitrequest),
        .host_readdata(host_readdata), .host_readdatavalid(host_readdatavalid),
        .host_resp_err(host_resp_err), .host_grant(host_grant), .conflict_err(conflict_err),
        .emif_read(emif_read), .emif_write(emif_write), .emif_address(emif_address),
        .emif_wdata(emif_wdata), .emif_rdata(emif_rdata)
`ifdef FDAS_CALBUS_ARB_STATS_EN
        , .host_acc_cnt(host_acc_cnt), .preempt_cnt(preempt_cnt)
`endif
    );

    always #5 calbus_clk = ~calbus_clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        int                cyc;
    } exp_rd_t;

    exp_rd_t sb_q[$];
    exp_rd_t mon_e;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge calbus_clk) cyc <= cyc + 1;

    always @(negedge calbus_clk) begin
        if (rst_n && host_readdatavalid) begin
            if (sb_q.size() == 0) begin
                chk("rdv_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rd_data", 64'(host_readdata), 64'(mon_e.data));
                chk("rd_err", 64'(host_resp_err), 64'(mon_e.err));
                chk("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge calbus_clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_wait"}, 64'(host_waitrequest), 64'd1);
        chk({tag, "_grant"}, 64'(host_grant), 64'd0);
        chk({tag, "_rdv"}, 64'(host_readdatavalid), 64'd0);
        chk({tag, "_rerr"}, 64'(host_resp_err), 64'd0);
        chk({tag, "_rdata"}, 64'(host_readdata), 64'd0);
        chk({tag, "_conflict"}, 64'(conflict_err), 64'd0);
        chk({tag, "_emif"}, {emif_read, emif_write, 10'd0, emif_address, emif_wdata}, 64'd0);
    endtask

    // Cal is idle from the current cycle on; grant must appear after exactly QUIET idle edges.
    task automatic wait_quiet(input string tag);
        for (int i = 1; i <= QUIET; i++) begin
            step();
            if (i == QUIET - 1) begin
                chk({tag, "_grant_early"}, 64'(host_grant), 64'd0);
                chk({tag, "_wait_early"}, 64'(host_waitrequest), 64'd1);
            end
            if (i == QUIET) chk({tag, "_grant"}, 64'(host_grant), 64'd1);
        end
    endtask

    task automatic host_op(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic err, input string tag,
                           output int acc_cyc);
        host_read = rd; host_write = wr; host_address = addr; host_wdata = wd;
        acc_cyc = -1;
        for (int i = 0; i < 200 && acc_cyc < 0; i++) begin
            #2;
            if (!host_waitrequest) begin
                acc_cyc = cyc;
                chk({tag, "_emif_addr"}, 64'(emif_address), 64'(addr));
                if (rd) begin
                    exp_rd_t e;
                    chk({tag, "_emif_rw"}, {62'd0, emif_read, emif_write}, 64'b10);
                    e.data = emif_rdata; e.err = err; e.cyc = cyc + RD_LAT;
                    sb_q.push_back(e);
                end else begin
                    chk({tag, "_emif_rw"}, {62'd0, emif_read, emif_write}, 64'b01);
                    chk({tag, "_emif_wdata"}, 64'(emif_wdata), 64'(wd));
                end
            end
            #1;
            step();
        end
        if (acc_cyc < 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
        host_read = 1'b0; host_write = 1'b0;
    endtask

    int c0, c1;

    initial begin
        #3;
        check_reset_outs("rst");
        step();
        rst_n = 1'b1;

        // cal reads pass straight through while cal owns the bus
        for (int i = 0; i < 10; i++) begin
            cal_read = 1'b1; cal_address = 20'h00100;
            emif_rdata = 32'h1110_0000 + 32'(i) * 32'h111;
            #2;
            chk("cal_rd_addr", 64'(emif_address), 64'h00100);
            chk("cal_rd_strobe", {62'd0, emif_read, emif_write}, 64'b10);
            chk("cal_rdata", 64'(cal_rdata), 64'(emif_rdata));
            chk("cal_rd_wait", {62'd0, host_waitrequest, host_grant}, 64'b10);
            step();
        end
        cal_read = 1'b0;
        wait_quiet("q1");

        host_op(1'b0, 1'b1, 20'h0A000, 32'hDEADBEEF, 1'b0, "hwr", c0);

        // back-to-back reads: second must wait for the first return cycle
        emif_rdata = 32'h12345678;
        host_op(1'b1, 1'b0, 20'h0A004, '0, 1'b0, "hrd1", c0);
        host_read = 1'b1; host_address = 20'h0A008;
        #2;
        chk("hrd2_blocked", 64'(host_waitrequest), 64'd1);
        #1;
        step();
        host_op(1'b1, 1'b0, 20'h0A008, '0, 1'b0, "hrd2", c1);
        chk("hrd2_accept_cyc", 64'(c1), 64'(c0 + RD_LAT));
        step(); step();
        chk("no_conflict_yet", 64'(conflict_err), 64'd0);

        // preemption of an in-flight read
        host_op(1'b1, 1'b0, 20'h0A010, '0, 1'b1, "hrd3", c0);
        cal_write = 1'b1; cal_address = 20'h00200; cal_wdata = 32'hCAFE0001;
        #2;
        chk("pre_emif_rw", {62'd0, emif_read, emif_write}, 64'b01);
        chk("pre_emif_addr", 64'(emif_address), 64'h00200);
        chk("pre_emif_wdata", 64'(emif_wdata), 64'hCAFE0001);
        step();
        cal_write = 1'b0;
        chk("pre_grant", 64'(host_grant), 64'd0);
        chk("pre_conflict", 64'(conflict_err), 64'd1);
        wait_quiet("q2");

        // simultaneous read+write: read first, write after the read completes
        host_op(1'b1, 1'b1, 20'h0A020, 32'h55AA55AA, 1'b0, "rw_rd", c0);
        host_op(1'b0, 1'b1, 20'h0A020, 32'h55AA55AA, 1'b0, "rw_wr", c1);
        chk("rw_wr_cyc", 64'(c1), 64'(c0 + RD_LAT));

        // host request held across a cal strobe is refused, then served later
        host_write = 1'b1; host_address = 20'h0A030; host_wdata = 32'h0BADF00D;
        cal_read = 1'b1; cal_address = 20'h00300;
        #2;
        chk("held_wait", 64'(host_waitrequest), 64'd1);
        chk("held_emif_rw", {62'd0, emif_read, emif_write}, 64'b10);
        chk("held_emif_addr", 64'(emif_address), 64'h00300);
        step();
        cal_read = 1'b0;
        chk("held_grant", 64'(host_grant), 64'd0);
        wait_quiet("q3");
        host_op(1'b0, 1'b1, 20'h0A030, 32'h0BADF00D, 1'b0, "held_wr", c0);
        chk("conflict_sticky", 64'(conflict_err), 64'd1);
`ifdef FDAS_CALBUS_ARB_STATS_EN
        chk("stat_acc", 64'(host_acc_cnt), 64'd7);
        chk("stat_pre", 64'(preempt_cnt), 64'd2);
`endif

        // reset during an in-flight read discards it
        emif_rdata = 32'h77770000;
        host_op(1'b1, 1'b0, 20'h0A040, '0, 1'b0, "hrd_rst", c0);
        rst_n = 1'b0;
        #2;
        sb_q.delete();
        check_reset_outs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_rdv", 64'(host_readdatavalid), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_grant", 64'(host_grant), 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fdas_calbus_arbiter.md
Name: fdas_calbus_arbiter

Overview:
Shares one EMIF calibration component bus (calbus) between the EMIF calibration IP and a host register requester (debug/config reads and writes of EMIF sequencer space). The calibration IP always has priority. The calbus has no waitrequest, so the arbiter forwards calibration traffic unstalled and grants the host only after a quiet window. One instance sits per EMIF channel (channel 0 and channel 1) between the calibration IP and the EMIF.

Parameters:
ADDR_W, 20, calbus address width
DATA_W, 32, calbus data width
RD_LATENCY, 2, calbus_clk cycles from read strobe to valid emif_rdata (range 1..7)
QUIET_CYCLES, 64, consecutive idle cal cycles before host grant (range 1..255)

Ports:
calbus_clk  in  1  calbus clock, the single clock of the block
rst_n  in  1  asynchronous active-low reset
cal_read  in  1  calibration IP read strobe
cal_write  in  1  calibration IP write strobe
cal_address  in  ADDR_W  calibration IP address
cal_wdata  in  DATA_W  calibration IP write data
cal_rdata  out  DATA_W  read data returned to calibration IP
host_read  in  1  host read request
host_write  in  1  host write request
host_address  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_waitrequest  out  1  high = host request not accepted this cycle
host_readdata  out  DATA_W  host read data
host_readdatavalid  out  1  one-cycle pulse with host_readdata
host_resp_err  out  1  qualifies host_readdatavalid: data corrupted by cal preemption
host_grant  out  1  high while host may issue
conflict_err  out  1  sticky: host op preempted by cal; cleared only by reset
emif_read  out  1  calbus read to EMIF
emif_write  out  1  calbus write to EMIF
emif_address  out  ADDR_W  calbus address to EMIF
emif_wdata  out  DATA_W  calbus write data to EMIF
emif_rdata  in  DATA_W  calbus read data from EMIF

Behaviour:
- Reset: state CAL_OWN, quiet counter 0; host_waitrequest=1; all other outputs 0; the read-tracking shift register is cleared.
- cal_act = cal_read|cal_write. Whenever cal_act=1, the emif_* outputs equal the cal_* inputs combinationally in the same cycle, in any state (zero added latency).
- cal_rdata = emif_rdata, passed through combinationally at all times.
- CAL_OWN: host_waitrequest=1. Counter increments on each cycle with cal_act=0 and resets to 0 on cal_act=1. When the counter reaches QUIET_CYCLES, go to HOST.
- HOST: host_grant=1. host_waitrequest = cal_act | rd_busy. A host op is accepted when (host_read|host_write) & ~host_waitrequest, and drives emif_* that same cycle.
  - A host read sets the tracking bit. host_readdatavalid pulses exactly RD_LATENCY cycles later with host_readdata = emif_rdata. rd_busy is high until that pulse.
  - A host write completes in 1 cycle.
  - host_read and host_write together: the read wins and the write stays waiting.
- Preemption: cal_act=1 in HOST moves to CAL_OWN next cycle and clears the counter.
  - If cal_act is seen while a host read is in flight, that read still returns its pulse at the scheduled cycle with host_resp_err=1, and conflict_err is set.
  - A host request held during a cal_act cycle is not accepted (waitrequest=1). It is not lost; it stays pending for the host to retry.
- Only one host read is outstanding at a time. No host op is accepted outside HOST.
- Reset mid-operation: an in-flight host read is discarded and no readdatavalid is produced.

Optional Feature:
FDAS_CALBUS_ARB_STATS_EN.
- Defined: adds outputs host_acc_cnt[15:0] (accepted host ops) and preempt_cnt[15:0] (cal preemptions of HOST state). Both counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and the counters are absent, with no other change.

Decomposition:
- Package fdas_calbus_pkg holds:
  - the state enum (CAL_OWN, HOST);
  - CALBUS_ADDR_W=20 and CALBUS_DATA_W=32;
  - a calbus request struct {read, write, address, wdata}.
- Natural sub-module: fdas_calbus_rd_tracker. It is the RD_LATENCY-deep shift register carrying {valid, err} and produces host_readdatavalid, host_resp_err and rd_busy.

Test Plan:
- Reset, then a cal read to 0x00100 each cycle for 10 cycles -> emif_address=0x00100 same cycle; cal_rdata mirrors emif_rdata; host_waitrequest stays 1 and host_grant=0.
- Cal idle 63 cycles -> host_grant=0. On the 64th idle cycle -> host_grant=1, and a host write to 0x0A000 with data 0xDEADBEEF appears on emif_* in the acceptance cycle.
- In HOST, host read at 0x0A004 with emif_rdata=0x12345678 -> host_readdatavalid pulses exactly 2 cycles later with host_resp_err=0. A second read issued back-to-back waits until that pulse.
- Host read accepted, then cal_write asserted the next cycle -> emif_* carries cal values; host read returns with host_resp_err=1; conflict_err=1; host_grant drops; a fresh 64-cycle quiet window is required.
- host_read and host_write asserted together in HOST -> read accepted first, write accepted after the read completes.
- Assert rst_n low during an in-flight host read -> no readdatavalid; all outputs at reset values; conflict_err cleared.
